// File: rtl/soc_video_pkg.sv
// Shared video types and helpers for the SoC video output stages.
package soc_video_pkg;

  localparam int COLOR_W    = 8;
  localparam int FACTOR_W   = COLOR_W + 1;
  localparam int HOLD_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    BLACK    = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  // Scale a colour by factor/256; factor 256 is unity, factor 1 gives 0.
  function automatic logic [COLOR_W-1:0] scale_color(
    input logic [COLOR_W-1:0]  c,
    input logic [FACTOR_W-1:0] f
  );
    logic [2*COLOR_W:0] prod;
    prod = {{FACTOR_W{1'b0}}, c} * {{COLOR_W{1'b0}}, f};
    return prod[2*COLOR_W-1:COLOR_W];
  endfunction

endpackage

// File: rtl/vga_fade_scale.sv
// One colour channel: register colour/DE/factor, then scale and blank.
module vga_fade_scale
  import soc_video_pkg::*;
(
  input  logic                pixel_clock,
  input  logic                reset_n,
  input  logic [COLOR_W-1:0]  i_color,
  input  logic                i_de,
  input  logic [FACTOR_W-1:0] i_factor,
  output logic [COLOR_W-1:0]  o_color
);

  logic [COLOR_W-1:0]  r_s1_color;
  logic                r_s1_de;
  logic [FACTOR_W-1:0] r_s1_factor;
  logic [COLOR_W-1:0]  r_s2_color;

  // Stage 1: capture the pixel and the brightness factor for this pixel.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_color  <= {COLOR_W{1'b0}};
      r_s1_de     <= 1'b0;
      r_s1_factor <= {FACTOR_W{1'b0}};
    end else begin
      r_s1_color  <= i_color;
      r_s1_de     <= i_de;
      r_s1_factor <= i_factor;
    end
  end

  // Stage 2: scaled colour, forced to black outside the active area.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_color <= {COLOR_W{1'b0}};
    end else if (r_s1_de) begin
      r_s2_color <= scale_color(r_s1_color, r_s1_factor);
    end else begin
      r_s2_color <= {COLOR_W{1'b0}};
    end
  end

  assign o_color = r_s2_color;

endmodule

// File: rtl/vga_fader.sv
// Frame-stepped global brightness fade (out, hold black, back in) on a VGA stream.
module vga_fader
  import soc_video_pkg::*;
#(
  parameter int FADE_STEP   = 4,
  parameter int HOLD_FRAMES = 60
) (
  input  logic               pixel_clock,
  input  logic               reset_n,
  input  logic [COLOR_W-1:0] in_r,
  input  logic [COLOR_W-1:0] in_g,
  input  logic [COLOR_W-1:0] in_b,
  input  logic               in_hs,
  input  logic               in_vs,
  input  logic               in_de,
  input  logic               in_hblank,
  input  logic               in_vblank,
  input  logic               fade_req,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_DE,
  output logic               VGA_HBLANK,
  output logic               VGA_VBLANK,
  output logic [COLOR_W-1:0] brightness,
  output logic               busy
);

  localparam logic [FACTOR_W-1:0]   STEP_9   = FACTOR_W'(FADE_STEP);
  localparam logic [HOLD_CNT_W-1:0] HOLD_MAX = HOLD_CNT_W'(HOLD_FRAMES);
  localparam logic [COLOR_W-1:0]    FULL     = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0]    ZERO     = {COLOR_W{1'b0}};

  fade_state_t           r_state;
  fade_state_t           w_state_nxt;
  logic [COLOR_W-1:0]    r_bright;
  logic [COLOR_W-1:0]    w_bright_nxt;
  logic [HOLD_CNT_W-1:0] r_hold_cnt;
  logic [HOLD_CNT_W-1:0] w_hold_nxt;
  logic                  r_busy;
  logic                  r_vblank_q;
  logic                  w_tick;
  logic [FACTOR_W-1:0]   w_dec;
  logic [FACTOR_W-1:0]   w_inc;
  logic [COLOR_W-1:0]    w_dec_sat;
  logic [COLOR_W-1:0]    w_inc_sat;
  logic [FACTOR_W-1:0]   w_factor;
  logic [4:0]            r_sync_d1;
  logic [4:0]            r_sync_d2;

  // A borrow/carry into bit 8 marks saturation, so no value ever wraps.
  assign w_dec     = {1'b0, r_bright} - STEP_9;
  assign w_inc     = {1'b0, r_bright} + STEP_9;
  assign w_dec_sat = w_dec[COLOR_W] ? ZERO : w_dec[COLOR_W-1:0];
  assign w_inc_sat = w_inc[COLOR_W] ? FULL : w_inc[COLOR_W-1:0];
  assign w_tick    = in_vblank & ~r_vblank_q;
  assign w_factor  = {1'b0, r_bright} + {{COLOR_W{1'b0}}, 1'b1};

  // Remember last vblank level to find its rising edge (the frame tick).
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vblank_q <= 1'b0;
    end else begin
      r_vblank_q <= in_vblank;
    end
  end

  // Fade sequencer: brightness and hold count move only on frame ticks.
  always_comb begin
    w_state_nxt  = r_state;
    w_bright_nxt = r_bright;
    w_hold_nxt   = r_hold_cnt;
    case (r_state)
      IDLE: begin
        if (fade_req) begin
          w_state_nxt = FADE_OUT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FADE_OUT: begin
        if (w_tick) begin
          w_bright_nxt = w_dec_sat;
          if (w_dec_sat == ZERO) begin
            w_state_nxt = BLACK;
            w_hold_nxt  = {HOLD_CNT_W{1'b0}};
          end else begin
            w_state_nxt = FADE_OUT;
          end
        end else begin
          w_state_nxt = FADE_OUT;
        end
      end
      BLACK: begin
        if (w_tick) begin
          if (r_hold_cnt == HOLD_MAX) begin
            w_state_nxt = FADE_IN;
          end else begin
            w_hold_nxt = r_hold_cnt + {{(HOLD_CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          w_state_nxt = BLACK;
        end
      end
      FADE_IN: begin
        if (w_tick) begin
          w_bright_nxt = w_inc_sat;
          if (w_inc_sat == FULL) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = FADE_IN;
          end
        end else begin
          w_state_nxt = FADE_IN;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_bright_nxt = FULL;
      end
    endcase
  end

  // Sequencer state, brightness, hold counter and registered busy flag.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_bright   <= FULL;
      r_hold_cnt <= {HOLD_CNT_W{1'b0}};
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bright   <= w_bright_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  // Two-stage delay for syncs/blanks/DE, matching the colour pipeline.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_d1 <= 5'd0;
      r_sync_d2 <= 5'd0;
    end else begin
      r_sync_d1 <= {in_hs, in_vs, in_de, in_hblank, in_vblank};
      r_sync_d2 <= r_sync_d1;
    end
  end

  vga_fade_scale u_scale_r (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .i_color     (in_r),
    .i_de        (in_de),
    .i_factor    (w_factor),
    .o_color     (VGA_R)
  );

  vga_fade_scale u_scale_g (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .i_color     (in_g),
    .i_de        (in_de),
    .i_factor    (w_factor),
    .o_color     (VGA_G)
  );

  vga_fade_scale u_scale_b (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .i_color     (in_b),
    .i_de        (in_de),
    .i_factor    (w_factor),
    .o_color     (VGA_B)
  );

  assign {VGA_HS, VGA_VS, VGA_DE, VGA_HBLANK, VGA_VBLANK} = r_sync_d2;
  assign brightness = r_bright;
  assign busy       = r_busy;

endmodule

// File: tb/tb_vga_fader.sv
// Directed bench for vga_fader: passthrough, fade out/hold/in, scaling, reset.
module tb_vga_fader;

  logic       pixel_clock = 1'b0;
  logic       reset_n;
  logic [7:0] in_r, in_g, in_b;
  logic       in_hs, in_vs, in_de, in_hblank, in_vblank, fade_req;
  logic [7:0] VGA_R, VGA_G, VGA_B, brightness;
  logic       VGA_HS, VGA_VS, VGA_DE, VGA_HBLANK, VGA_VBLANK, busy;
  logic [4:0] ctl_out;

  int n_checks = 0;
  int n_fail   = 0;

  assign ctl_out = {VGA_HS, VGA_VS, VGA_DE, VGA_HBLANK, VGA_VBLANK};

  vga_fader #(.FADE_STEP(4), .HOLD_FRAMES(2)) dut (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .in_r        (in_r),
    .in_g        (in_g),
    .in_b        (in_b),
    .in_hs       (in_hs),
    .in_vs       (in_vs),
    .in_de       (in_de),
    .in_hblank   (in_hblank),
    .in_vblank   (in_vblank),
    .fade_req    (fade_req),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_DE      (VGA_DE),
    .VGA_HBLANK  (VGA_HBLANK),
    .VGA_VBLANK  (VGA_VBLANK),
    .brightness  (brightness),
    .busy        (busy)
  );

  always #5 pixel_clock = ~pixel_clock;

  // Expected colour: (c * (bright+1)) >> 8, zero when DE is low.
  function automatic logic [7:0] exp_px(input logic [7:0] c, input logic [7:0] br, input logic de);
    logic [16:0] p;
    p = {9'd0, c} * ({9'd0, br} + 17'd1);
    return de ? p[15:8] : 8'd0;
  endfunction

  // Apply one cycle of inputs (ctl = {hs,vs,de,hblank,vblank}); return 1ns after the edge.
  // Values applied in one call are visible on the outputs after the following call.
  task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [4:0] ctl, input logic req);
    in_r = r; in_g = g; in_b = b;
    {in_hs, in_vs, in_de, in_hblank, in_vblank} = ctl;
    fade_req = req;
    @(posedge pixel_clock);
    #1;
  endtask

  // Short frame: 3 active pixels then 2 vblank cycles; the first vblank cycle is the tick.
  task automatic frame(input logic req_tick, input logic req_act);
    drive(8'h10, 8'h20, 8'h30, 5'b00100, req_act);
    drive(8'h11, 8'h21, 8'h31, 5'b00100, 1'b0);
    drive(8'h12, 8'h22, 8'h32, 5'b00100, 1'b0);
    drive(8'h00, 8'h00, 8'h00, 5'b01011, req_tick);
    drive(8'h00, 8'h00, 8'h00, 5'b00011, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(8'hAA, 8'h55, 8'hFF, 5'b11111, 1'b1);
    drive(8'hAA, 8'h55, 8'hFF, 5'b11111, 1'b1);
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'd0) begin
      n_fail++; $display("FAIL reset_rgb: got %h expected 000000", {VGA_R, VGA_G, VGA_B});
    end
    n_checks++;
    if (ctl_out !== 5'd0) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 00000", ctl_out);
    end
    n_checks++;
    if (brightness !== 8'd255 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got bright=%0d busy=%b expected 255/0", brightness, busy);
    end
    reset_n = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 5'b00000, 1'b0);
    drive(8'h00, 8'h00, 8'h00, 5'b00000, 1'b0);
  endtask

  task automatic test_passthrough();
    logic [7:0] vr [0:5];
    logic [7:0] vg [0:5];
    logic [7:0] vb [0:5];
    logic [4:0] vc [0:5];
    vr = '{8'h80, 8'h80, 8'h12, 8'hFF, 8'h01, 8'h80};
    vg = '{8'h40, 8'h40, 8'h34, 8'h00, 8'h02, 8'h40};
    vb = '{8'hFF, 8'hFF, 8'h56, 8'h7F, 8'h03, 8'hFF};
    vc = '{5'b00100, 5'b10100, 5'b01000, 5'b00110, 5'b00011, 5'b00100};
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive(vr[i], vg[i], vb[i], vc[i], 1'b0);
      else       drive(8'h00, 8'h00, 8'h00, 5'b00000, 1'b0);
      if (i >= 1) begin
        n_checks++;
        if ({VGA_R, VGA_G, VGA_B} !== {exp_px(vr[i-1], 8'd255, vc[i-1][2]),
                                       exp_px(vg[i-1], 8'd255, vc[i-1][2]),
                                       exp_px(vb[i-1], 8'd255, vc[i-1][2])}) begin
          n_fail++; $display("FAIL pass_rgb[%0d]: got %h expected %h%h%h", i-1, {VGA_R, VGA_G, VGA_B},
                             exp_px(vr[i-1], 8'd255, vc[i-1][2]), exp_px(vg[i-1], 8'd255, vc[i-1][2]),
                             exp_px(vb[i-1], 8'd255, vc[i-1][2]));
        end
        n_checks++;
        if (ctl_out !== vc[i-1]) begin
          n_fail++; $display("FAIL pass_ctl[%0d]: got %b expected %b", i-1, ctl_out, vc[i-1]);
        end
      end
    end
    n_checks++;
    if (brightness !== 8'd255 || busy !== 1'b0) begin
      n_fail++; $display("FAIL pass_state: got bright=%0d busy=%b expected 255/0", brightness, busy);
    end
  endtask

  task automatic test_req_on_tick();
    frame(1'b1, 1'b0);
    n_checks++;
    if (brightness !== 8'd255 || busy !== 1'b1) begin
      n_fail++; $display("FAIL req_tick_same: got bright=%0d busy=%b expected 255/1", brightness, busy);
    end
    frame(1'b0, 1'b0);
    n_checks++;
    if (brightness !== 8'd251) begin
      n_fail++; $display("FAIL req_tick_next: got %0d expected 251", brightness);
    end
    frame(1'b0, 1'b1);
    n_checks++;
    if (brightness !== 8'd247 || busy !== 1'b1) begin
      n_fail++; $display("FAIL req_ignored: got bright=%0d busy=%b expected 247/1", brightness, busy);
    end
  endtask

  task automatic test_scale();
    for (int k = 3; k <= 32; k++) begin
      frame(1'b0, 1'b0);
      n_checks++;
      if (brightness !== 8'(255 - 4 * k)) begin
        n_fail++; $display("FAIL fade_out_tick%0d: got %0d expected %0d", k, brightness, 255 - 4 * k);
      end
    end
    drive(8'd200, 8'd255, 8'd1, 5'b00100, 1'b0);
    drive(8'd200, 8'd200, 8'd200, 5'b00000, 1'b0);
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== {8'd100, 8'd127, 8'd0} || VGA_DE !== 1'b1) begin
      n_fail++; $display("FAIL scale127: got %0d/%0d/%0d de=%b expected 100/127/0 de=1", VGA_R, VGA_G, VGA_B, VGA_DE);
    end
    drive(8'h00, 8'h00, 8'h00, 5'b00000, 1'b0);
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'd0 || VGA_DE !== 1'b0) begin
      n_fail++; $display("FAIL blank_de0: got %0d/%0d/%0d de=%b expected 0/0/0 de=0", VGA_R, VGA_G, VGA_B, VGA_DE);
    end
  endtask

  task automatic test_fade_out();
    for (int k = 33; k <= 64; k++) begin
      frame(1'b0, 1'b0);
      n_checks++;
      if (brightness !== ((k == 64) ? 8'd0 : 8'(255 - 4 * k))) begin
        n_fail++; $display("FAIL fade_out_tick%0d: got %0d expected %0d", k, brightness, (k == 64) ? 0 : 255 - 4 * k);
      end
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL black_busy: got %b expected 1", busy);
    end
  endtask

  task automatic test_hold_fade_in();
    for (int h = 1; h <= 3; h++) begin
      frame(1'b0, 1'b0);
      n_checks++;
      if (brightness !== 8'd0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL hold_tick%0d: got bright=%0d busy=%b expected 0/1", h, brightness, busy);
      end
    end
    for (int k = 1; k <= 64; k++) begin
      frame(1'b0, 1'b0);
      n_checks++;
      if (brightness !== ((k == 64) ? 8'd255 : 8'(4 * k)) || busy !== (k < 64)) begin
        n_fail++; $display("FAIL fade_in_tick%0d: got bright=%0d busy=%b expected %0d/%b",
                           k, brightness, busy, (k == 64) ? 255 : 4 * k, (k < 64));
      end
    end
    frame(1'b0, 1'b0);
    n_checks++;
    if (brightness !== 8'd255 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_in: got bright=%0d busy=%b expected 255/0", brightness, busy);
    end
  endtask

  task automatic test_reset_mid_fade();
    frame(1'b1, 1'b0);
    for (int k = 1; k <= 38; k++) frame(1'b0, 1'b0);
    n_checks++;
    if (brightness !== 8'd103) begin
      n_fail++; $display("FAIL mid_fade_level: got %0d expected 103", brightness);
    end
    drive(8'd200, 8'd200, 8'd200, 5'b00100, 1'b0);
    drive(8'd200, 8'd200, 8'd200, 5'b00100, 1'b0);
    n_checks++;
    if (VGA_R !== 8'd81) begin
      n_fail++; $display("FAIL mid_fade_pixel: got %0d expected 81", VGA_R);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'd0 || ctl_out !== 5'd0) begin
      n_fail++; $display("FAIL async_reset_out: got %h ctl=%b expected 0", {VGA_R, VGA_G, VGA_B}, ctl_out);
    end
    n_checks++;
    if (brightness !== 8'd255 || busy !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_state: got bright=%0d busy=%b expected 255/0", brightness, busy);
    end
    #2;
    reset_n = 1'b1;
    drive(8'h80, 8'h40, 8'hFF, 5'b10100, 1'b0);
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'd0 || ctl_out !== 5'd0) begin
      n_fail++; $display("FAIL refill_cycle1: got %h ctl=%b expected 0", {VGA_R, VGA_G, VGA_B}, ctl_out);
    end
    drive(8'h00, 8'h00, 8'h00, 5'b00000, 1'b0);
    n_checks++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h8040FF || ctl_out !== 5'b10100) begin
      n_fail++; $display("FAIL refill_cycle2: got %h ctl=%b expected 8040ff/10100", {VGA_R, VGA_G, VGA_B}, ctl_out);
    end
    frame(1'b0, 1'b0);
    n_checks++;
    if (brightness !== 8'd255 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got bright=%0d busy=%b expected 255/0", brightness, busy);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
    in_hs = 1'b0; in_vs = 1'b0; in_de = 1'b0; in_hblank = 1'b0; in_vblank = 1'b0;
    fade_req = 1'b0;
    #2;
    test_reset();
    test_passthrough();
    test_req_on_tick();
    test_scale();
    test_fade_out();
    test_hold_fade_in();
    test_reset_mid_fade();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
